serial_cmp_ctrl: RTL

SERIAL_CMP_CTRL -- requirements
Module: serial_cmp_ctrl

---
 rtl/serial_cmp_pkg.sv | 23 ++
 rtl/cmp_bit_counter.sv | 29 ++
 rtl/serial_cmp_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/serial_cmp_pkg.sv
// Shared definitions for the serial compare controller: datapath width,
// shift-counter width, FSM state encoding and the signed-order bias helper.
package serial_cmp_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_CAPT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Flipping the MSB maps two's-complement order onto unsigned order, so the
  // external unsigned comparator can serve signed compares as well.
  function automatic logic [WIDTH-1:0] bias_msb(input logic [WIDTH-1:0] v,
                                                input logic sgn);
    return v ^ {sgn, {(WIDTH-1){1'b0}}};
  endfunction

endpackage

// File: rtl/cmp_bit_counter.sv
// Counts the bit positions shifted through the serial comparator. Clear has
// priority over enable; the count wraps to zero after the terminal value.
module cmp_bit_counter #(
  parameter int                CNT_W = serial_cmp_pkg::CNT_W,
  parameter logic [CNT_W-1:0]  LAST  = CNT_W'(serial_cmp_pkg::WIDTH - 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] count;

  assign tc = (count == LAST);

  // Count register: reset/clear to zero, advance while enabled, wrap at LAST.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/serial_cmp_ctrl.sv
// Controller for a bit-serial magnitude comparator: loads the operands,
// shifts all bit positions through the comparator, then captures its flags.
module serial_cmp_ctrl #(
  parameter int WIDTH = serial_cmp_pkg::WIDTH,
  parameter int CNT_W = serial_cmp_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] cmp_A,
  output logic [WIDTH-1:0] cmp_B,
  output logic             cmp_sel,
  output logic             cmp_op,
  output logic             cmp_clr,
  input  logic             cmp_L,
  input  logic             cmp_E,
  input  logic             cmp_G,
  output logic             busy,
  output logic             done,
  output logic             res_lt,
  output logic             res_eq,
  output logic             res_gt
);

  import serial_cmp_pkg::*;

  state_t state;
  state_t state_nxt;
  logic   load;
  logic   capture;
  logic   clr_fsm;
  logic   cnt_clr;
  logic   cnt_en;
  logic   cnt_tc;

  cmp_bit_counter #(
    .CNT_W (CNT_W),
    .LAST  (CNT_W'(WIDTH - 1))
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc    (cnt_tc)
  );

  // The comparator is held cleared for as long as reset is asserted.
  assign cmp_clr = clr_fsm | ~reset;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and state-decoded comparator/status controls.
  always_comb begin
    state_nxt = state;
    cmp_sel   = 1'b0;
    cmp_op    = 1'b1;
    clr_fsm   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    load      = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cmp_sel   = 1'b1;
        cmp_op    = 1'b0;
        clr_fsm   = 1'b1;
        busy      = 1'b1;
        cnt_clr   = 1'b1;
        state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        cmp_op = 1'b0;
        busy   = 1'b1;
        cnt_en = 1'b1;
        if (cnt_tc) begin
          state_nxt = ST_CAPT;
        end
      end
      ST_CAPT: begin
        busy      = 1'b1;
        capture   = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Operand registers feeding the comparator, biased for signed compares.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cmp_A <= '0;
      cmp_B <= '0;
    end else if (load) begin
      cmp_A <= bias_msb(a_in, sgn);
      cmp_B <= bias_msb(b_in, sgn);
    end
  end

  // Result flags: "equal" after reset, updated only when a compare completes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      res_lt <= 1'b0;
      res_eq <= 1'b1;
      res_gt <= 1'b0;
    end else if (capture) begin
      res_lt <= cmp_L;
      res_eq <= cmp_E;
      res_gt <= cmp_G;
    end
  end

endmodule
